beat_upsizer: RTL
=================

Name: beat_upsizer

Overview:
- Downstream neighbour of the downsizer stage.
- Consumes narrow DATA_IN_WIDTH-byte beats qualified by an enable strobe that carries no backpressure. Repacks them into OUT_DATA_WIDTH-byte words, first beat in the least-significant bytes.
- Presents the words on a valid/ready interface through a 2-entry output buffer.
- Supports flushing a partial word and flags overflow when the consumer stalls too long.

Parameters:
- DATA_IN_WIDTH, 32, input beat width in bytes.
- OUT_DATA_WIDTH, 128, output word width in bytes; integer multiple of DATA_IN_WIDTH, ratio a power of two ≥2.
- RATIO, OUT_DATA_WIDTH/DATA_IN_WIDTH, beats per full word (derived).
- CNT_WIDTH, $clog2(RATIO), beat counter width (derived).
- BYTES_WIDTH, $clog2(OUT_DATA_WIDTH)+1, width of the byte-count field (derived).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- inp_data  input  DATA_IN_WIDTH*8  narrow beat.
- in_en  input  1  beat valid; a beat is always taken when high, no stall.
- flush  input  1  close the current partial word.
- in_ready  output  1  high when the output buffer has ≥1 free entry (advisory only).
- out_data  output  OUT_DATA_WIDTH*8  packed word at buffer head.
- out_bytes  output  BYTES_WIDTH  valid byte count of out_data, from the LSB.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts head when out_valid && out_ready.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
Reset
- Async on rstn low: beat counter=0, pack register=0, buffer empty.
- Outputs: out_valid=0, out_data=0, out_bytes=0, overflow=0, in_ready=1.
- Reset mid-word or with a full buffer discards all held data.

Packing
- Beat k (counter value k) is written to pack bytes [k*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- Counter increments on each accepted beat.
- On in_en with counter==RATIO-1: the completed word {inp_data, pack[low bytes]} is pushed the same edge, with out_bytes=OUT_DATA_WIDTH. Counter wraps to 0 and the pack register clears to 0.
- Latency: out_valid rises the cycle after the final beat's edge when the buffer was empty.
- Back-to-back words need no bubble. The output is a 2-entry FIFO; head on out_data/out_bytes, registered, no combinational path from inputs to outputs.

Flush
- flush && counter>0 && !in_en: push pack, zero-filled above, with out_bytes=counter*DATA_IN_WIDTH; counter→0.
- flush && in_en: the beat is included first. Push with out_bytes=(counter+1)*DATA_IN_WIDTH. If this completes the word, exactly one full word is pushed.
- flush && counter==0 && !in_en: no-op, no empty word is pushed.

Buffer and handshake
- Pop when out_valid && out_ready. out_valid deasserts the cycle after the last entry pops.
- Push and pop in the same cycle are both honoured, in every occupancy state.
- Push when full with no simultaneous pop: the word is dropped and overflow is set; buffer contents are unchanged. Counter and pack still reset, so packing resynchronises on the next beat.
- overflow is cleared only by rstn.
- in_ready = !full | (out_valid && out_ready).
- out_data/out_bytes hold stable while out_valid && !out_ready.

Width rules
- out_bytes computed at BYTES_WIDTH, max value OUT_DATA_WIDTH. The counter never exceeds RATIO-1.

Test Plan:
1. Full words: reset, out_ready=1, 4 consecutive beats 0x11..,0x22..,0x33..,0x44.. (each byte-replicated) → one cycle after beat 4, out_valid=1. out_data bytes 0-31=0x11, 32-63=0x22, 64-95=0x33, 96-127=0x44; out_bytes=128.
2. Partial flush: 2 beats then flush alone → out_bytes=64, bytes 64-127=0x00. flush with counter 0 → no out_valid.
3. Flush with beat: 2 beats, then in_en+flush on beat 3 → out_bytes=96. Flush together with beat 4 → single word, out_bytes=128.
4. Backpressure/overflow: out_ready=0, 12 continuous beats → words 1-2 buffered, in_ready=0 after word 2, word 3 dropped, overflow=1. Release out_ready → words 1 and 2 in order, then out_valid=0; overflow stays 1.
5. Full-buffer push+pop: buffer full, out_ready=1 on the cycle word 3 completes → no overflow; word 3 appears after word 2.
6. Async reset: rstn low after 3 beats with 1 word buffered → out_valid=0 immediately. After release, 4 new beats produce a word with no stale data.

Source files
------------

// File: rtl/beat_upsizer_if.sv
`default_nettype none
// ============================================================================
// Module      : beat_upsizer_if
// Description : Narrow-beat input and wide valid/ready output bundle of the
//               beat upsizer. The master drives beats and consumes words.
// Revision    : 1.0 - initial release
// ============================================================================
interface beat_upsizer_if #(
  parameter int DATA_IN_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 128
);
  localparam int BYTES_WIDTH = $clog2(OUT_DATA_WIDTH) + 1;

  logic [DATA_IN_WIDTH*8-1:0]  inp_data;
  logic                        in_en;
  logic                        flush;
  logic                        in_ready;
  logic [OUT_DATA_WIDTH*8-1:0] out_data;
  logic [BYTES_WIDTH-1:0]      out_bytes;
  logic                        out_valid;
  logic                        out_ready;
  logic                        overflow;

  modport master (
    output inp_data, in_en, flush, out_ready,
    input  in_ready, out_data, out_bytes, out_valid, overflow
  );

  modport slave (
    input  inp_data, in_en, flush, out_ready,
    output in_ready, out_data, out_bytes, out_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/beat_upsizer.sv
`default_nettype none
// ============================================================================
// Module      : beat_upsizer
// Description : Packs narrow beats (first beat in the LSBs) into wide words,
//               supports flushing a partial word, and presents words through
//               a 2-entry registered FIFO with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_upsizer #(
  parameter int DATA_IN_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 128
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  beat_upsizer_if.slave  bus
);
  localparam int RATIO       = OUT_DATA_WIDTH / DATA_IN_WIDTH;
  localparam int CNT_WIDTH   = $clog2(RATIO);
  localparam int BYTES_WIDTH = $clog2(OUT_DATA_WIDTH) + 1;
  localparam int IN_BITS     = DATA_IN_WIDTH * 8;
  localparam int OUT_BITS    = OUT_DATA_WIDTH * 8;

  // Packing state
  logic [CNT_WIDTH-1:0]   cnt_q,  cnt_d;
  logic [OUT_BITS-1:0]    pack_q, pack_d;

  // Output FIFO state
  logic [OUT_BITS-1:0]    mem_q       [2];
  logic [BYTES_WIDTH-1:0] mem_bytes_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;
  logic                   ovf_q;

  // Combinational helpers
  logic [OUT_BITS-1:0]    w_merged;
  logic [OUT_BITS-1:0]    w_push_data;
  logic [BYTES_WIDTH-1:0] w_push_bytes;
  logic [BYTES_WIDTH-1:0] w_cnt_ext;
  logic                   w_push;
  logic                   w_last;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;

  assign w_cnt_ext = BYTES_WIDTH'(cnt_q);
  assign w_last    = (cnt_q == CNT_WIDTH'(RATIO - 1));

  // Pack register with the incoming beat dropped into the lane picked by the counter
  always_comb begin
    w_merged = pack_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CNT_WIDTH'(k)) begin
        w_merged[k*IN_BITS +: IN_BITS] = bus.inp_data;
      end
    end
  end

  // Decide whether a word closes this cycle and what the packer holds next
  always_comb begin
    w_push       = 1'b0;
    w_push_data  = pack_q;
    w_push_bytes = w_cnt_ext * BYTES_WIDTH'(DATA_IN_WIDTH);
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    if (bus.in_en) begin
      if (w_last || bus.flush) begin
        // Beat is included before closing; a flush on the last beat still yields one word
        w_push       = 1'b1;
        w_push_data  = w_merged;
        w_push_bytes = (w_cnt_ext + BYTES_WIDTH'(1)) * BYTES_WIDTH'(DATA_IN_WIDTH);
        cnt_d        = '0;
        pack_d       = '0;
      end else begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        pack_d = w_merged;
      end
    end else if (bus.flush && (cnt_q != '0)) begin
      // Upper lanes are already zero because the pack register clears on every close
      w_push = 1'b1;
      cnt_d  = '0;
      pack_d = '0;
    end
  end

  assign w_full = (count_q == 2'd2);
  assign w_pop  = (count_q != 2'd0) && bus.out_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  // Packer registers; they resynchronise even when the closed word is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

  // Two-entry output FIFO with sticky overflow on a push into a full, non-draining buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < 2; e++) begin
        mem_q[e]       <= '0;
        mem_bytes_q[e] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_wr) begin
        mem_q[wr_ptr_q]       <= w_push_data;
        mem_bytes_q[wr_ptr_q] <= w_push_bytes;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_wr, w_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (w_push && !w_wr) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_bytes = mem_bytes_q[rd_ptr_q];
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.in_ready  = !w_full || w_pop;
  assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire
